// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/handshake bundle between the multi-cycle MIPS controller and its datapath
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       bus_err;
    logic       ill_op;
    modport master (
        input  op, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, bus_err, ill_op
    );
    modport slave (
        output op, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, bus_err, ill_op
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with memory ready handshake, wait timeout and illegal-op fault
module multicycle_ctrl #(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] DECODE  = 4'd2;
    localparam logic [3:0] MEMADR  = 4'd3;
    localparam logic [3:0] MEMRD   = 4'd4;
    localparam logic [3:0] MEMWB   = 4'd5;
    localparam logic [3:0] MEMWR   = 4'd6;
    localparam logic [3:0] RTYPEEX = 4'd7;
    localparam logic [3:0] ALUWB   = 4'd8;
    localparam logic [3:0] BEQEX   = 4'd9;
    localparam logic [3:0] ADDIEX  = 4'd10;
    localparam logic [3:0] ADDIWB  = 4'd11;
    localparam logic [3:0] JEX     = 4'd12;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    logic [3:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q;
    logic            waiting, tmo, legal;
    assign legal   = bus.op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    assign waiting = (state_q inside {FETCH, MEMRD, MEMWR}) & ~bus.mem_ready;
    // tmo fires on the TO_MAX-th consecutive wait cycle, aborting the access
    assign tmo     = waiting & (cnt_q == TO_W'(TO_MAX - 1));
    assign cnt_d   = (waiting && !tmo) ? cnt_q + TO_W'(1) : '0;
    assign bus.bus_err = bus_err_q;
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:  state_d = bus.op == OP_R ? RTYPEEX :
                               (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                               bus.op == OP_BEQ ? BEQEX :
                               bus.op == OP_ADDI ? ADDIEX :
                               bus.op == OP_J ? JEX : FETCH;
            MEMADR:  state_d = bus.op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   state_d = bus.mem_ready ? MEMWB : tmo ? FETCH : MEMRD;
            MEMWR:   state_d = (bus.mem_ready || tmo) ? FETCH : MEMWR;
            RTYPEEX: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.aluop    = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.ill_op   = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                bus.ill_op  = ~legal;
            end
            MEMADR, ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BEQEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.pcwrite = bus.zero;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_q | tmo;
        end
    end
endmodule
